// File: rtl/delay_sched_pkg.sv
// Shared types and helpers for the timestamp-based SRAM delay-line scheduler.
package delay_sched_pkg;

    localparam int unsigned TS_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Wrapping age (now - head) reduced to the low w bits; callers narrower than
    // TS_W_DEFAULT truncate the result to their own width.
    function automatic logic [TS_W_DEFAULT-1:0] ts_age(
        input logic [TS_W_DEFAULT-1:0] now,
        input logic [TS_W_DEFAULT-1:0] head,
        input int unsigned             w
    );
        logic [TS_W_DEFAULT-1:0] mask;
        mask = (w >= TS_W_DEFAULT) ? '1 : ((TS_W_DEFAULT'(1) << w) - TS_W_DEFAULT'(1));
        return (now - head) & mask;
    endfunction

endpackage

// File: rtl/delay_sched_ts_fifo.sv
// Single-clock timestamp FIFO with a block-RAM body and a registered head word.
module ts_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  rd_data_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          byp_q, byp_d;
    logic [W-1:0]  byp_data_q, byp_data_d;
    logic          do_push, do_pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = byp_q ? byp_data_q : rd_data_q;

    always_comb begin
        do_push    = push & ~full & ~clear;
        do_pop     = pop & ~empty & ~clear;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        byp_d      = 1'b0;
        byp_data_d = byp_data_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
            // A word landing in an otherwise-empty FIFO becomes the head directly.
            if (do_push && ((cnt_q - CW'(do_pop)) == '0)) begin
                byp_d      = 1'b1;
                byp_data_d = din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
        rd_data_q <= mem[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
        end
    end

endmodule

// File: rtl/delay_sched.sv
// Releases SRAM FIFO words once each has aged cfg_delay cycles; owns the run/stop/flush FSM.
module delay_sched
    import delay_sched_pkg::*;
#(
    parameter int unsigned TS_W         = TS_W_DEFAULT,
    parameter int unsigned TS_DEPTH     = 1024,
    parameter int unsigned FLUSH_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [TS_W-1:0] cfg_delay,
    input  logic            cfg_valid,
    input  logic            flush,
    input  logic            in_wr_req,
    output logic            in_wr_en,
    input  logic            data_full,
    input  logic            data_empty,
    input  logic            dn_prog_full,
    output logic            out_rd_en,
    output logic            data_fifo_rst,
    output logic [31:0]     drop_cnt,
    output logic [1:0]      state
);
    localparam int unsigned FC_W = $clog2(FLUSH_CYCLES + 1);

    state_e          state_q, state_d;
    logic [TS_W-1:0] now_q, now_d;
    logic [TS_W-1:0] delay_q, delay_d;
    logic            rd_en_q, rd_en_d;
    logic            fifo_rst_q, fifo_rst_d;
    logic [31:0]     drop_q, drop_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic [TS_W-1:0] ts_head, age_c;
    logic            ts_full, ts_empty, ts_clear;

    assign out_rd_en     = rd_en_q;
    assign data_fifo_rst = fifo_rst_q;
    assign drop_cnt      = drop_q;
    assign state         = state_q;
    assign ts_clear      = (state_q == ST_FLUSH);

    ts_fifo #(.W(TS_W), .DEPTH(TS_DEPTH)) u_ts_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (ts_clear),
        .push  (in_wr_en),
        .din   (now_q),
        .pop   (rd_en_q),
        .head  (ts_head),
        .full  (ts_full),
        .empty (ts_empty)
    );

    always_comb begin
        in_wr_en = in_wr_req & ~ts_full & ~data_full & (state_q != ST_FLUSH);
        now_d    = now_q + TS_W'(1);
        delay_d  = cfg_valid ? cfg_delay : delay_q;
        drop_d   = drop_q;
        if (in_wr_req && !in_wr_en && (drop_q != '1)) drop_d = drop_q + 32'd1;

        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_STOP: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
                end else if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
                end else if (!enable) begin
                    state_d = ST_STOP;
                end
            end
            ST_FLUSH: begin
                if (flush) begin
                    fcnt_d = FC_W'(FLUSH_CYCLES - 1);
                end else if (fcnt_q == '0) begin
                    state_d = enable ? ST_RUN : ST_STOP;
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end
            end
            default: state_d = ST_STOP;
        endcase

        // The release is held off for a cycle after each pop so the new head is compared.
        age_c   = TS_W'(ts_age(TS_W_DEFAULT'(now_q), TS_W_DEFAULT'(ts_head), TS_W));
        rd_en_d = (state_q == ST_RUN) & ~flush & ~ts_empty & ~data_empty & ~dn_prog_full
                & (age_c >= delay_q) & ~rd_en_q;
        fifo_rst_d = (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_STOP;
            now_q      <= '0;
            delay_q    <= '0;
            rd_en_q    <= 1'b0;
            fifo_rst_q <= 1'b0;
            drop_q     <= '0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            now_q      <= now_d;
            delay_q    <= delay_d;
            rd_en_q    <= rd_en_d;
            fifo_rst_q <= fifo_rst_d;
            drop_q     <= drop_d;
            fcnt_q     <= fcnt_d;
        end
    end

endmodule
